// File: rtl/relu_serializer.sv
// Two-bank parallel-to-serial bridge with optional signed ReLU at capture.
// Streams a captured vector LANES words per beat over valid/ready.
`timescale 1ns/1ps
module relu_serializer #(
    parameter int DATA_WIDTH = 24,
    parameter int NUM_NODES  = 500,
    parameter int LANES      = 1,
    parameter bit RELU_EN    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    output logic                  i_ready,
    input  logic [DATA_WIDTH-1:0] din [NUM_NODES],
    output logic                  o_valid,
    input  logic                  o_ready,
    output logic [DATA_WIDTH-1:0] dout [LANES],
    output logic [LANES-1:0]      o_keep,
    output logic                  o_first,
    output logic                  o_last,
    output logic                  o_overrun
);

    localparam int BEATS = (NUM_NODES + LANES - 1) / LANES;
    localparam int BW    = $clog2(BEATS + 1);
    localparam int NW    = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    logic [1:0]    occ_q, occ_d;
    logic [BW-1:0] beat_q, beat_d;
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic          ovr_q, ovr_d;
    logic          acc, pop, fin;

    logic [DATA_WIDTH-1:0] bank_q [2][NUM_NODES];

    assign i_ready   = (occ_q != 2'd2);
    assign o_valid   = (occ_q != 2'd0);
    assign acc       = i_valid & i_ready;
    assign pop       = o_valid & o_ready;
    assign fin       = pop & (beat_q == LAST_BEAT);
    assign o_first   = o_valid & (beat_q == '0);
    assign o_last    = o_valid & (beat_q == LAST_BEAT);
    assign o_overrun = ovr_q;

    always_comb begin
        occ_d    = occ_q;
        beat_d   = beat_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovr_d    = ovr_q | (i_valid & ~i_ready);
        if (acc) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) begin
            beat_d = fin ? '0 : beat_q + 1'b1;
        end
        if (fin) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        // accept and final pop on one edge cancel out
        unique case ({acc, fin})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ_q    <= 2'd0;
            beat_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            occ_q    <= occ_d;
            beat_q   <= beat_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovr_q    <= ovr_d;
        end
    end

    // data storage carries no reset; validity comes from occ_q
    always_ff @(posedge clk) begin
        if (acc) begin
            for (int n = 0; n < NUM_NODES; n++) begin
                if (RELU_EN && din[n][DATA_WIDTH-1]) begin
                    bank_q[wr_ptr_q][n] <= '0;
                end else begin
                    bank_q[wr_ptr_q][n] <= din[n];
                end
            end
        end
    end

    always_comb begin
        int idx;
        idx    = 0;
        o_keep = '0;
        for (int l = 0; l < LANES; l++) begin
            idx     = int'(beat_q) * LANES + l;
            dout[l] = '0;
            if (o_valid && idx < NUM_NODES) begin
                dout[l]   = bank_q[rd_ptr_q][NW'(idx)];
                o_keep[l] = 1'b1;
            end
        end
    end

endmodule

// File: doc/relu_serializer.md
# relu_serializer

Parametrised parallel-to-serial bridge between two linear layers of the MNIST accelerator core. It captures a full layer output vector in one cycle and applies optional signed ReLU at capture. It then streams the vector to the next layer LANES words per beat over a valid/ready handshake. Two internal banks let a new vector be accepted while the previous one drains, replacing the single-buffer register file and free-running serializer of the first-generation core.

## Interface
- DATA_WIDTH, 24, width of one signed two's-complement activation word
- NUM_NODES, 500, words per input vector (≥1)
- LANES, 1, words emitted per output beat (1..NUM_NODES); BEATS = ceil(NUM_NODES/LANES)
- RELU_EN, 1, 1: clamp negative words to 0 at capture; 0: pass through unchanged

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-low reset
- i_valid  in  1  din holds a complete vector
- i_ready  out  1  a bank is free (occupancy < 2)
- din  in  DATA_WIDTH x NUM_NODES (unpacked)  parallel input vector
- o_valid  out  1  dout carries a valid beat
- o_ready  in  1  downstream accepts beat
- dout  out  DATA_WIDTH x LANES (unpacked)  lane l = word beat*LANES+l
- o_keep  out  LANES  per-lane valid; low for padding lanes of the final beat
- o_first  out  1  beat 0 of a vector
- o_last  out  1  beat BEATS-1 of a vector
- o_overrun  out  1  sticky: i_valid seen while i_ready low

## Operation
- Accept = i_valid & i_ready at a rising edge. din is copied, after ReLU if RELU_EN, into the bank at wr_ptr. wr_ptr toggles. Occupancy increments.
- Pop = o_valid & o_ready. beat_cnt increments. On the last beat, beat_cnt returns to 0, rd_ptr toggles and occupancy decrements.
- Accept and final-beat pop on the same edge: occupancy is unchanged, and both pointers toggle.
- Occupancy range is 0..2. i_ready = (occupancy != 2), driven from registered state only, with no combinational path from o_ready.
- o_valid = (occupancy != 0).
- dout[l] = bank[rd_ptr][beat_cnt*LANES+l] when that index < NUM_NODES, else 0. o_keep[l] follows the same condition.
- o_first = o_valid & (beat_cnt==0). o_last = o_valid & (beat_cnt==BEATS-1). When BEATS=1, both are high on the same beat.
- While o_valid & !o_ready, dout, o_keep, o_first and o_last are held stable.
- ReLU is a signed test on the MSB. RELU_EN=0 leaves words bit-exact.
- o_overrun sets on any edge with i_valid & !i_ready and stays set until reset. A refused vector is dropped and not queued.
- beat_cnt is $clog2(BEATS+1) bits wide; occupancy is 2 bits wide.
- Bank contents are not reset. Only control state is reset.

## Timing
- Reset (rst low, asynchronous): occupancy=0, beat_cnt=0, wr_ptr=rd_ptr=0, o_overrun=0.
  - Outputs are forced immediately: o_valid=0, i_ready=1, o_keep=0, o_first=0, o_last=0, dout=0.
  - Release is synchronous to clk. The first accept is possible on the first rising edge with rst high.
- Latency: a vector accepted at edge N presents beat 0 with o_valid=1 from edge N to N+1.
- Throughput: BEATS cycles per vector with o_ready held high. Back-to-back vectors stream with no bubble.
- Full: after two accepts without a completed drain, i_ready=0. It returns to 1 the cycle after the final-beat pop.
- Reset mid-stream: any partial vector and any queued vector are discarded. The next accepted vector starts at beat 0.

## Test plan
- Reset values: drive rst=0 mid-cycle -> all outputs take reset values without a clock edge. After release, i_ready=1 and o_valid=0.
- NUM_NODES=5, LANES=2, RELU_EN=1: accept din={3,-1,7,-8,2} with o_ready=1.
  - Required beats: {3,0} keep=11 first=1; {7,0} keep=11; {2,0} keep=01 last=1.
  - o_valid is high for exactly 3 cycles, starting the cycle after accept.
- Same vector with RELU_EN=0 and o_ready toggling 1,0,0,1,... -> beats {3,-1},{7,-8},{2,0}. dout is stable during each stall, and no beat is lost or duplicated.
- Overflow: accept vectors A and B with o_ready=0, then assert i_valid with C.
  - Required: i_ready=0, C dropped, o_overrun=1.
  - Then o_ready=1 -> A then B stream out. o_overrun stays 1.
- Simultaneous events: occupancy=1, offer vector B on the same edge as A's final-beat pop.
  - Required: B beat 0 on the very next cycle, with o_first=1 and occupancy still 1.
- Reset mid-stream: pulse rst low during beat 1 of a vector, then accept a new vector -> its beat 0 is emitted with o_first=1, and no stale data appears.
